// File: rtl/mem_bus_pkg.sv
// Shared defaults and types for the relay-memory bus sequencer.
package mem_bus_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RESP
  } mem_state_t;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } mem_op_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter; done_c flags a zero count so the current phase can exit.
module phase_timer #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done_c
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done_c = (cnt == '0);

endmodule

// File: rtl/mem_access_seq.sv
// Bus-master sequencer: runs setup/strobe/hold timed read and write cycles
// against the relay memory and reports each completion with a response pulse.
module mem_access_seq
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] addr_bus,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  input  logic [DATA_W-1:0] data_in,
  output logic              mem_read,
  output logic              mem_write,
  output logic              busy
);

  localparam int unsigned MAX_CYC = max3(SETUP_CYC, STROBE_CYC, HOLD_CYC);
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  mem_state_t        state, next_state;
  mem_op_t           op_q, op_nx;
  logic [ADDR_W-1:0] addr_q, addr_nx;
  logic [DATA_W-1:0] wdata_q, wdata_nx;
  logic [DATA_W-1:0] rdata_q;
  logic              accept_c;
  logic              active_nx;
  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_val;
  logic              tmr_done;

  phase_timer #(
    .CNT_W(CNT_W)
  ) u_phase_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (tmr_load),
    .load_val(tmr_val),
    .done_c  (tmr_done)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state, phase-timer reload and next request payload
  always_comb begin
    next_state = state;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    accept_c   = req_valid && req_ready;
    op_nx      = op_q;
    addr_nx    = addr_q;
    wdata_nx   = wdata_q;
    active_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (accept_c) begin
          next_state = SETUP;
          tmr_load   = 1'b1;
          tmr_val    = CNT_W'(SETUP_CYC - 1);
          op_nx      = mem_op_t'(req_write);
          addr_nx    = req_addr;
          wdata_nx   = req_wdata;
        end
      end
      SETUP: begin
        if (tmr_done) begin
          next_state = STROBE;
          tmr_load   = 1'b1;
          tmr_val    = CNT_W'(STROBE_CYC - 1);
        end
      end
      STROBE: begin
        if (tmr_done) begin
          next_state = HOLD;
          tmr_load   = 1'b1;
          tmr_val    = CNT_W'(HOLD_CYC - 1);
        end
      end
      HOLD: begin
        if (tmr_done) begin
          next_state = RESP;
        end
      end
      RESP: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    active_nx = (next_state == SETUP) || (next_state == STROBE) || (next_state == HOLD);
  end

  // Request latch and read capture on the last strobe cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= READ;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      op_q    <= op_nx;
      addr_q  <= addr_nx;
      wdata_q <= wdata_nx;
      if ((state == STROBE) && tmr_done && (op_q == READ)) begin
        rdata_q <= data_in;
      end
    end
  end

  // Outputs registered from the next state so they line up with the state itself
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_bus  <= '0;
      data_out  <= '0;
      data_oe   <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      busy      <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      addr_bus  <= active_nx ? addr_nx : '0;
      data_oe   <= active_nx && (op_nx == WRITE);
      data_out  <= (active_nx && (op_nx == WRITE)) ? wdata_nx : '0;
      mem_read  <= (next_state == STROBE) && (op_nx == READ);
      mem_write <= (next_state == STROBE) && (op_nx == WRITE);
      rsp_valid <= (next_state == RESP);
      busy      <= (next_state != IDLE);
      req_ready <= (next_state == IDLE);
      if ((state == HOLD) && (next_state == RESP)) begin
        rsp_rdata <= (op_q == WRITE) ? '0 : rdata_q;
      end
    end
  end

endmodule
